pio_alert_in_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for board alert/status lines (power-monitor alert, fault pins).

---
 rtl/pio_alert_in_irq.sv | 148 ++++++++++++++
 tb/tb_pio_alert_in_irq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_alert_in_irq.sv
// pio_alert_in_irq
//   Avalon-MM input PIO for board alert/status lines. Each input bit goes
//   through a metastability synchroniser and an optional glitch filter.
//   Rising, falling or any edges of the filtered level are captured into a
//   write-1-to-clear register. A maskable, registered IRQ output is driven
//   either by the captured edges or by the filtered level.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data, bits [WIDTH-1:0] used
//   readdata    registered read data (1-cycle latency), upper bits zero
//   in_port     asynchronous alert inputs
//   irq         registered interrupt request, active-high
module pio_alert_in_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      rd_mux;
    logic             irq_next;
    logic             wr_en;
    logic             unused_bits;

    // Upper writedata bits are only meaningful for WIDTH=32.
    assign unused_bits = ^writedata;

    // Synchroniser chain; sync_q is the final stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    generate
        if (FILTER_LEN > 0) begin : g_filt
            localparam int CNT_W = $clog2(FILTER_LEN + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

            logic [CNT_W-1:0] cnt [WIDTH];
            logic [WIDTH-1:0] filt_r;

            // A level is accepted only after it has differed from the current
            // filtered value for FILTER_LEN consecutive cycles; any return to
            // the accepted level restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_r <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_q[i] == filt_r[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            filt_r[i] <= sync_q[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end

            assign filt = filt_r;
        end else begin : g_nofilt
            assign filt = sync_q;
        end
    endgenerate

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = filt & ~filt_d;
            1:       edge_det = ~filt & filt_d;
            default: edge_det = filt ^ filt_d;
        endcase
    end

    assign wr_en    = chipselect & ~write_n;
    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = filt;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    assign irq_next = (IRQ_TYPE == 1) ? |(edgecapture & irqmask) : |(filt & irqmask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d      <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            filt_d <= filt;
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A new edge in the same cycle as its clear keeps the bit set.
            edgecapture <= (edgecapture & ~edge_clr) | edge_det;
            readdata    <= rd_mux;
            irq         <= irq_next;
        end
    end

endmodule

// File: tb/tb_pio_alert_in_irq.sv
// tb_pio_alert_in_irq
//   Two instances share the bus: A (rising edges, edge IRQ) and B (any edge,
//   level IRQ). A behavioural model tracks each pin's history and is compared
//   against readdata and irq every cycle; directed phases add fixed-value checks.
module tb_pio_alert_in_irq;

    localparam int SYNC = 2;
    localparam int FLEN = 4;
    localparam int HN   = 8192;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [7:0]  hist [2][HN];
    int          t;
    logic [7:0]  m_filt [2];
    logic [7:0]  m_filt_d [2];
    int          m_run [2][8];
    logic [7:0]  m_ec [2];
    logic [7:0]  m_mask [2];
    logic [31:0] m_rd [2];
    logic        m_irq [2];

    pio_alert_in_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN),
                       .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a));

    pio_alert_in_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN),
                       .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_b), .irq(irq_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        t = 0;
        for (int k = 0; k < 2; k++) begin
            m_filt[k] = 0; m_filt_d[k] = 0; m_ec[k] = 0; m_mask[k] = 0;
            m_rd[k] = 0; m_irq[k] = 0;
            for (int i = 0; i < 8; i++) m_run[k][i] = 0;
        end
    endtask

    // Advance one clock: model computes the post-edge state from the
    // pre-edge inputs, then DUT outputs are compared at the next negedge.
    task automatic step();
        logic [7:0]  s, nf, edg, clr, nec, nmask;
        logic [31:0] nrd;
        logic        nirq, wr;
        wr = chipselect && !write_n;
        for (int k = 0; k < 2; k++) begin
            s  = (t >= SYNC) ? hist[k][(t - SYNC) % HN] : 8'h00;
            nf = m_filt[k];
            for (int i = 0; i < 8; i++) begin
                if (s[i] != m_filt[k][i]) begin
                    m_run[k][i]++;
                    if (m_run[k][i] == FLEN) begin
                        nf[i] = s[i];
                        m_run[k][i] = 0;
                    end
                end else begin
                    m_run[k][i] = 0;
                end
            end
            if (k == 0) edg = m_filt[k] & ~m_filt_d[k];
            else        edg = m_filt[k] ^ m_filt_d[k];
            clr   = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
            nec   = (m_ec[k] & ~clr) | edg;
            nmask = (wr && address == 2'd2) ? writedata[7:0] : m_mask[k];
            case (address)
                2'd0:    nrd = {24'd0, m_filt[k]};
                2'd2:    nrd = {24'd0, m_mask[k]};
                2'd3:    nrd = {24'd0, m_ec[k]};
                default: nrd = 32'd0;
            endcase
            if (k == 0) nirq = (m_ec[k] & m_mask[k]) != 0;
            else        nirq = (m_filt[k] & m_mask[k]) != 0;
            hist[k][t % HN] = (k == 0) ? in_a : in_b;
            m_filt_d[k] = m_filt[k];
            m_filt[k]   = nf;
            m_ec[k]     = nec;
            m_mask[k]   = nmask;
            m_rd[k]     = nrd;
            m_irq[k]    = nirq;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
        chk("rd_a",  rd_a,  m_rd[0]);
        chk("irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
        chk("rd_b",  rd_b,  m_rd[1]);
        chk("irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear
    // without waiting for a clock edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_rd_a",  rd_a, 32'd0);
        chk("rst_async_irq_a", {31'd0, irq_a}, 32'd0);
        chk("rst_async_rd_b",  rd_b, 32'd0);
        chk("rst_async_irq_b", {31'd0, irq_b}, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rd_a", rd_a, 32'd0);
        chk("rst_hold_irq_b", {31'd0, irq_b}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] a;
        int r;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        chk("init_rd_a", rd_a, 32'd0);
        chk("init_irq_a", {31'd0, irq_a}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // data path latency
        address = 2'd0;
        in_a = 8'hA5;
        hold(SYNC + FLEN + 2);
        chk("t1_data", rd_a, 32'h0000_00A5);
        bus_read(2'd3);
        chk("t1_ec", rd_a, 32'h0000_00A5);

        // glitch rejection and minimum accepted pulse
        bus_write(2'd3, 32'hFF);
        in_a = 8'hAD; hold(3); in_a = 8'hA5; hold(10);
        bus_read(2'd0);
        chk("t2_glitch_data", rd_a, 32'h0000_00A5);
        bus_read(2'd3);
        chk("t2_glitch_ec", rd_a, 32'h0000_0000);
        in_a = 8'hAD; hold(4); in_a = 8'hA5; hold(10);
        bus_read(2'd3);
        chk("t2_pulse_ec", rd_a, 32'h0000_0008);

        // edge IRQ, write-0 no effect, write-1 clear
        bus_write(2'd2, 32'h08);
        step();
        chk("t3_irq_set", {31'd0, irq_a}, 32'd1);
        bus_write(2'd3, 32'h00);
        bus_read(2'd3);
        chk("t3_w0_keeps", rd_a, 32'h0000_0008);
        bus_write(2'd3, 32'h08);
        step();
        chk("t3_irq_clr", {31'd0, irq_a}, 32'd0);

        // set wins over clear in the same cycle
        in_a = 8'hA1; hold(10);
        bus_write(2'd3, 32'hFF);
        in_a = 8'hA5; hold(SYNC + FLEN);
        bus_write(2'd3, 32'h04);
        bus_read(2'd3);
        chk("t4_set_wins", rd_a, 32'h0000_0004);

        // any-edge capture and level IRQ on instance B
        in_b = 8'h01; hold(10);
        bus_read(2'd3);
        chk("t5_rise_cap", rd_b, 32'h0000_0001);
        bus_write(2'd3, 32'h01);
        in_b = 8'h00; hold(10);
        bus_read(2'd3);
        chk("t5_fall_cap", rd_b, 32'h0000_0001);
        bus_write(2'd2, 32'h01);
        in_b = 8'h01; hold(10);
        chk("t5_lvl_irq", {31'd0, irq_b}, 32'd1);
        bus_write(2'd2, 32'h00);
        step();
        chk("t5_mask_off", {31'd0, irq_b}, 32'd0);

        // reset mid-filter with irq asserted
        bus_write(2'd2, 32'h01);
        step();
        chk("t6_irq_pre", {31'd0, irq_b}, 32'd1);
        in_a = 8'hFF; hold(3);
        do_reset();
        bus_read(2'd2);
        chk("t6_mask_rst", rd_a, 32'd0);
        bus_read(2'd1);
        chk("t6_reserved", rd_b, 32'd0);
        bus_read(2'd3);
        chk("t6_ec_rst", rd_a, 32'd0);
        hold(10);
        bus_read(2'd0);
        chk("t6_data_after", rd_a, 32'h0000_00FF);
        bus_read(2'd3);
        chk("t6_rise_after", rd_a, 32'h0000_00FF);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            r = $urandom_range(0, 19);
            if (r < 2)       in_a = 8'($urandom);
            else if (r == 2) in_a = in_a ^ (8'h01 << $urandom_range(0, 7));
            r = $urandom_range(0, 19);
            if (r < 2)       in_b = 8'($urandom);
            else if (r == 2) in_b = in_b ^ (8'h01 << $urandom_range(0, 7));
            a = 2'($urandom_range(0, 3));
            address    = a;
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 5) != 0);
            step();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
